// File: rtl/ascii_to_ps2_seq.sv
// ---------------------------------------------------------------------------
// ascii_to_ps2_seq
//
// Purpose: turns one ASCII character at a time into the PS/2 Scan Code Set 2
// byte stream of a full key press and release. Plain keys send
// "code F0 code". Keypad '/' sends "E0 code E0 F0 code". With SHIFT_WRAP_EN
// defined, uppercase letters are wrapped in Left-Shift as
// "12 code F0 code F0 12". Without it, letters are case-insensitive.
//
// Configuration macro: SHIFT_WRAP_EN (optional Left-Shift wrapping).
//
// Parameters:
//   GAP_CYCLES  idle cycles after every accepted output byte (0..255)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_ascii   character to encode
//   in_valid   in_ascii valid
//   in_ready   character accepted this cycle (high only when idle)
//   out_data   scan-code byte
//   out_valid  out_data valid
//   out_ready  sink takes out_data this cycle
//   busy       a sequence is in progress
//   err        one-cycle pulse after an unsupported character is accepted
// ---------------------------------------------------------------------------
module ascii_to_ps2_seq #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_ascii,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic       ok;
    logic       ext;
    logic [7:0] code;
  } lut_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  // Character to scan-code table; letters are folded to uppercase first.
  function automatic lut_t lookup(input logic [7:0] ch);
    lut_t r;
    r.ok   = 1'b1;
    r.ext  = 1'b0;
    r.code = 8'h00;
    if (((ch >= 8'h41) && (ch <= 8'h5A)) || ((ch >= 8'h61) && (ch <= 8'h7A))) begin
      case (ch & 8'hDF)
        8'h41: r.code = 8'h1C;  8'h42: r.code = 8'h32;  8'h43: r.code = 8'h21;
        8'h44: r.code = 8'h23;  8'h45: r.code = 8'h24;  8'h46: r.code = 8'h2B;
        8'h47: r.code = 8'h34;  8'h48: r.code = 8'h33;  8'h49: r.code = 8'h43;
        8'h4A: r.code = 8'h3B;  8'h4B: r.code = 8'h42;  8'h4C: r.code = 8'h4B;
        8'h4D: r.code = 8'h3A;  8'h4E: r.code = 8'h31;  8'h4F: r.code = 8'h44;
        8'h50: r.code = 8'h4D;  8'h51: r.code = 8'h15;  8'h52: r.code = 8'h2D;
        8'h53: r.code = 8'h1B;  8'h54: r.code = 8'h2C;  8'h55: r.code = 8'h3C;
        8'h56: r.code = 8'h2A;  8'h57: r.code = 8'h1D;  8'h58: r.code = 8'h22;
        8'h59: r.code = 8'h35;  8'h5A: r.code = 8'h1A;
        default: r.ok = 1'b0;
      endcase
    end else begin
      case (ch)
        8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;  8'h32: r.code = 8'h1E;
        8'h33: r.code = 8'h26;  8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;
        8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;  8'h38: r.code = 8'h3E;
        8'h39: r.code = 8'h46;
        8'h2D: r.code = 8'h4E;  8'h3D: r.code = 8'h55;  8'h20: r.code = 8'h29;
        8'h0A: r.code = 8'h5A;  8'h2A: r.code = 8'h7C;  8'h2B: r.code = 8'h79;
        8'h2F: begin
          r.code = 8'h4A;
          r.ext  = 1'b1;
        end
        default: r.ok = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Byte number 'step' of the press/release sequence.
  function automatic logic [7:0] seq_byte(input logic [2:0] step, input logic [7:0] code,
                                          input logic ext, input logic shift);
    logic [7:0] b;
    b = 8'h00;
    if (shift) begin
      case (step)
        3'd0: b = 8'h12;  3'd1: b = code;  3'd2: b = 8'hF0;
        3'd3: b = code;   3'd4: b = 8'hF0; 3'd5: b = 8'h12;
        default: b = 8'h00;
      endcase
    end else if (ext) begin
      case (step)
        3'd0: b = 8'hE0;  3'd1: b = code;  3'd2: b = 8'hE0;
        3'd3: b = 8'hF0;  3'd4: b = code;
        default: b = 8'h00;
      endcase
    end else begin
      case (step)
        3'd0: b = code;  3'd1: b = 8'hF0;  3'd2: b = code;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] len_q, len_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  lut_t       lut_s;

`ifdef SHIFT_WRAP_EN
  logic       shift_q, shift_d;
`else
  // Shift is constant zero, so the 6-byte branch of seq_byte folds away.
  logic       shift_d;
  assign shift_d = 1'b0;
`endif

  // Next-state, sequence bookkeeping and next output values.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    gap_d   = gap_q;
    code_d  = code_q;
    ext_d   = ext_q;
    err_d   = 1'b0;
`ifdef SHIFT_WRAP_EN
    shift_d = shift_q;
`endif
    lut_s   = lookup(in_ascii);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (lut_s.ok) begin
            code_d  = lut_s.code;
            ext_d   = lut_s.ext;
`ifdef SHIFT_WRAP_EN
            shift_d = (in_ascii >= 8'h41) && (in_ascii <= 8'h5A);
`endif
            len_d   = shift_d ? 3'd6 : (lut_s.ext ? 3'd5 : 3'd3);
            step_d  = 3'd0;
            state_d = ST_EMIT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          step_d = step_q + 3'd1;
          if (GAP_LOAD != 8'd0) begin
            // The gap follows every byte, including the last one.
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else if (step_q == (len_q - 3'd1)) begin
            step_d  = 3'd0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d = 8'd0;
          // step has already advanced past the byte just sent.
          if (step_q == len_q) begin
            step_d  = 3'd0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
        gap_d   = 8'd0;
      end
    endcase

    out_valid_d = (state_d == ST_EMIT);
    out_data_d  = out_valid_d ? seq_byte(step_d, code_d, ext_d, shift_d) : 8'h00;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      len_q       <= 3'd0;
      gap_q       <= 8'd0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef SHIFT_WRAP_EN
      shift_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef SHIFT_WRAP_EN
      shift_q     <= shift_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
